// File: rtl/button_tally_ctrl.sv
// Three-button press tally: synchronise and debounce the active-low buttons,
// count presses over a timed window into a saturating 4-bit tally, then hold it for display.
//
// state   | meaning
// IDLE    | waiting for a press; tally shows the previous result
// COLLECT | window open; per-cycle press count added with saturation
// SHOW    | tally frozen, presses discarded until the hold time expires
module button_tally_ctrl #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int WINDOW_CYCLES   = 12000000,
    parameter int HOLD_CYCLES     = 6000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PMOD1,
    input  logic PMOD2,
    input  logic PMOD3,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic D4,
    output logic D5
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW  = $clog2(WINDOW_CYCLES + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0]  WIN_LAST  = WW'(WINDOW_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SHOW} state_t;

    state_t         state_q, state_d;
    logic [2:0]     pin_raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     stable_q, stable_d, stable_dly_q;
    logic [2:0]     press_q, press_d;
    logic [DBW-1:0] db_cnt_q [3];
    logic [DBW-1:0] db_cnt_d [3];
    logic [1:0]     n_inc;
    logic [4:0]     sum;
    logic [3:0]     tally_q, tally_d, tally_sat;
    logic [WW-1:0]  win_q, win_d;
    logic [HW-1:0]  hold_q, hold_d;

    assign pin_raw = {PMOD3, PMOD2, PMOD1};

    // The stable level flips on the cycle the mismatch count would reach DEBOUNCE_CYCLES.
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < 3; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = ~stable_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign press_d = stable_dly_q & ~stable_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            stable_q     <= '1;
            stable_dly_q <= '1;
            press_q      <= '0;
            for (int b = 0; b < 3; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q      <= pin_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            for (int b = 0; b < 3; b++) db_cnt_q[b] <= db_cnt_d[b];
        end
    end

    assign n_inc[0]  = ^press_q;
    assign n_inc[1]  = (press_q[0] & press_q[1]) | (press_q[0] & press_q[2]) | (press_q[1] & press_q[2]);
    assign sum       = {1'b0, tally_q} + {3'b000, n_inc};
    assign tally_sat = sum[4] ? 4'hF : sum[3:0];

    always_comb begin
        state_d = state_q;
        tally_d = tally_q;
        win_d   = win_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (n_inc != 2'd0) begin
                    tally_d = {2'b00, n_inc};
                    win_d   = WIN_LAST;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                tally_d = tally_sat;
                if (win_q == '0) begin
                    hold_d  = HOLD_LAST;
                    state_d = SHOW;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            SHOW: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            tally_q <= '0;
            win_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            tally_q <= tally_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
        end
    end

    assign D1 = tally_q[0];
    assign D2 = tally_q[1];
    assign D3 = tally_q[2];
    assign D4 = tally_q[3];
    assign D5 = (state_q == COLLECT);
endmodule

// File: tb/tb_button_tally_ctrl.sv
// Bench for button_tally_ctrl: directed scenarios plus random button waveforms checked
// against a pin-level debounce/window model; a second long-window instance exercises saturation.
`timescale 1ns/1ps
module tb_button_tally_ctrl;
    localparam int DB   = 4;
    localparam int WIN  = 32;
    localparam int WIN2 = 96;
    localparam int HOLD = 8;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic PMOD1 = 1'b1;
    logic PMOD2 = 1'b1;
    logic PMOD3 = 1'b1;
    logic D1, D2, D3, D4, D5;
    logic L1, L2, L3, L4, L5;

    int tests = 0;
    int fails = 0;

    // model state: debounced level and mismatch run per button, 4-edge press latency pipe
    int lvl [3];
    int run [3];
    int pipe [4];
    int edge_no;
    int m_tally, open_edge;
    int m_tally2, open_edge2;

    button_tally_ctrl #(.DEBOUNCE_CYCLES(DB), .WINDOW_CYCLES(WIN), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .RST_N(RST_N), .PMOD1(PMOD1), .PMOD2(PMOD2), .PMOD3(PMOD3),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5)
    );

    button_tally_ctrl #(.DEBOUNCE_CYCLES(DB), .WINDOW_CYCLES(WIN2), .HOLD_CYCLES(HOLD)) dut_long (
        .CLK(CLK), .RST_N(RST_N), .PMOD1(PMOD1), .PMOD2(PMOD2), .PMOD3(PMOD3),
        .D1(L1), .D2(L2), .D3(L3), .D4(L4), .D5(L5)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] tally_o();
        return {D4, D3, D2, D1};
    endfunction

    function automatic logic [3:0] tally_l();
        return {L4, L3, L2, L1};
    endfunction

    function automatic logic in_window(input int open, input int w);
        return (edge_no >= open) && (edge_no <= open + w - 1);
    endfunction

    // window opened at edge 'open' adds at edges open+1..open+w, then HOLD edges of lockout
    function automatic void win_update(input int n, input int w, inout int open, inout int tally);
        if (edge_no > open && edge_no <= open + w) begin
            tally = (tally + n > 15) ? 15 : tally + n;
        end else if (edge_no > open + w + HOLD && n > 0) begin
            open  = edge_no;
            tally = n;
        end
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            lvl[b] = 1;
            run[b] = 0;
        end
        for (int i = 0; i < 4; i++) pipe[i] = 0;
        edge_no    = 0;
        m_tally    = 0;
        open_edge  = -1000;
        m_tally2   = 0;
        open_edge2 = -1000;
    endtask

    task automatic step();
        logic [2:0] pins;
        int m;
        int n;
        @(posedge CLK);
        if (RST_N) begin
            pins = {PMOD3, PMOD2, PMOD1};
            edge_no++;
            m = 0;
            for (int b = 0; b < 3; b++) begin
                if (int'(pins[b]) != lvl[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        if (lvl[b] == 1) m++;
                        lvl[b] = int'(pins[b]);
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            n = pipe[3];
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = m;
            win_update(n, WIN, open_edge, m_tally);
            win_update(n, WIN2, open_edge2, m_tally2);
        end
        #1;
    endtask

    task automatic step_track(inout int entry, inout int drop, inout int rises, inout logic prev);
        step();
        if (D5 && !prev) begin
            rises++;
            if (entry < 0) entry = edge_no;
        end
        if (!D5 && prev && drop < 0) drop = edge_no;
        prev = D5;
    endtask

    task automatic test_reset();
        model_reset();
        RST_N = 1'b0;
        step();
        step();
        tests++;
        if ({D5, D4, D3, D2, D1} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_state: D5..D1=%b expected 00000", {D5, D4, D3, D2, D1});
        end
        RST_N = 1'b1;
        repeat (12) step();
        tests++;
        if ({D5, tally_o()} !== 5'b00000) begin
            fails++;
            $display("FAIL no_press_idle: D5..D1=%b expected 00000", {D5, tally_o()});
        end
    endtask

    task automatic test_debounce();
        PMOD1 = 1'b0;
        repeat (3) step();
        PMOD1 = 1'b1;
        step();
        PMOD1 = 1'b0;
        step();
        repeat (6) step();
        tests++;
        if (tally_o() !== 4'd0 || D5 !== 1'b0) begin
            fails++;
            $display("FAIL debounce_k6: tally=%0d D5=%b expected 0 0", tally_o(), D5);
        end
        step();
        tests++;
        if (tally_o() !== 4'd1 || D5 !== 1'b1) begin
            fails++;
            $display("FAIL debounce_k7: tally=%0d D5=%b expected 1 1", tally_o(), D5);
        end
        repeat (2) step();
        PMOD1 = 1'b1;
        repeat (WIN + HOLD + 4) step();
        tests++;
        if (tally_o() !== 4'd1 || D5 !== 1'b0) begin
            fails++;
            $display("FAIL debounce_single_event: tally=%0d D5=%b expected 1 0", tally_o(), D5);
        end
    endtask

    task automatic test_simultaneous();
        {PMOD3, PMOD2, PMOD1} = 3'b000;
        repeat (5) step();
        {PMOD3, PMOD2, PMOD1} = 3'b111;
        repeat (2) step();
        tests++;
        if (tally_o() !== 4'd1 || D5 !== 1'b0) begin
            fails++;
            $display("FAIL idle_holds_previous: tally=%0d D5=%b expected 1 0", tally_o(), D5);
        end
        step();
        tests++;
        if ({D5, D4, D3, D2, D1} !== 5'b10011) begin
            fails++;
            $display("FAIL simultaneous_three: D5..D1=%b expected 10011", {D5, D4, D3, D2, D1});
        end
        repeat (WIN + HOLD + 4) step();
        tests++;
        if (tally_o() !== 4'(m_tally)) begin
            fails++;
            $display("FAIL simultaneous_model: tally=%0d expected %0d", tally_o(), m_tally);
        end
    endtask

    task automatic test_saturation();
        int entry = -1;
        int drop  = -1;
        int rises = 0;
        logic prev = D5;
        for (int r = 0; r < 6; r++) begin
            {PMOD3, PMOD2, PMOD1} = 3'b000;
            repeat (DB) step_track(entry, drop, rises, prev);
            {PMOD3, PMOD2, PMOD1} = 3'b111;
            repeat (DB) step_track(entry, drop, rises, prev);
        end
        repeat (WIN) step_track(entry, drop, rises, prev);
        tests++;
        if (tally_o() !== 4'd15) begin
            fails++;
            $display("FAIL saturation_tally: tally=%0d expected 15", tally_o());
        end
        tests++;
        if (drop - entry !== WIN) begin
            fails++;
            $display("FAIL window_length: D5 high for %0d cycles expected %0d", drop - entry, WIN);
        end
        tests++;
        if (rises !== 1) begin
            fails++;
            $display("FAIL no_reopen: D5 rose %0d times expected 1", rises);
        end
        tests++;
        if (tally_l() !== 4'd15 || L5 !== 1'b1) begin
            fails++;
            $display("FAIL long_saturation: tally=%0d L5=%b expected 15 1", tally_l(), L5);
        end
    endtask

    task automatic test_lockout();
        int e;
        {PMOD3, PMOD1} = 2'b00;
        repeat (DB) step();
        {PMOD3, PMOD1} = 2'b11;
        for (int i = 0; i < 10 && !D5; i++) step();
        tests++;
        if (D5 !== 1'b1 || tally_o() !== 4'd2) begin
            fails++;
            $display("FAIL lockout_open: D5=%b tally=%0d expected 1 2", D5, tally_o());
        end
        e = edge_no;
        while (edge_no < e + WIN - 6) step();
        PMOD2 = 1'b0;
        repeat (DB + 1) step();
        PMOD2 = 1'b1;
        while (edge_no < e + WIN + HOLD - 7) step();
        PMOD1 = 1'b0;
        repeat (DB + 1) step();
        PMOD1 = 1'b1;
        repeat (2) step();
        tests++;
        if (tally_o() !== 4'd2 || D5 !== 1'b0) begin
            fails++;
            $display("FAIL lockout_discard: tally=%0d D5=%b expected 2 0", tally_o(), D5);
        end
        step();
        tests++;
        if (tally_o() !== 4'd1 || D5 !== 1'b1) begin
            fails++;
            $display("FAIL first_idle_opens: tally=%0d D5=%b expected 1 1", tally_o(), D5);
        end
        repeat (WIN + HOLD + 4) step();
    endtask

    task automatic test_reset_mid();
        {PMOD3, PMOD2, PMOD1} = 3'b000;
        repeat (DB) step();
        {PMOD3, PMOD2, PMOD1} = 3'b111;
        for (int i = 0; i < 10 && !D5; i++) step();
        {PMOD2, PMOD1} = 2'b00;
        repeat (DB) step();
        {PMOD2, PMOD1} = 2'b11;
        repeat (DB) step();
        tests++;
        if (tally_o() !== 4'd5 || D5 !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_tally: tally=%0d D5=%b expected 5 1", tally_o(), D5);
        end
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({D5, D4, D3, D2, D1} !== 5'b00000 || {L5, tally_l()} !== 5'b00000) begin
            fails++;
            $display("FAIL async_reset: D5..D1=%b long=%b expected 00000", {D5, D4, D3, D2, D1}, {L5, tally_l()});
        end
        model_reset();
        repeat (2) step();
        RST_N = 1'b1;
        repeat (15) step();
        tests++;
        if ({D5, tally_o()} !== 5'b00000) begin
            fails++;
            $display("FAIL post_reset_quiet: D5..D1=%b expected 00000", {D5, tally_o()});
        end
    endtask

    task automatic test_release_held();
        PMOD2 = 1'b0;
        RST_N = 1'b0;
        model_reset();
        repeat (2) step();
        RST_N = 1'b1;
        repeat (7) step();
        tests++;
        if (tally_o() !== 4'd0 || D5 !== 1'b0) begin
            fails++;
            $display("FAIL held_k6: tally=%0d D5=%b expected 0 0", tally_o(), D5);
        end
        step();
        tests++;
        if (tally_o() !== 4'd1 || D5 !== 1'b1) begin
            fails++;
            $display("FAIL held_k7: tally=%0d D5=%b expected 1 1", tally_o(), D5);
        end
        PMOD2 = 1'b1;
        repeat (WIN + HOLD + 6) step();
        tests++;
        if (tally_o() !== 4'd1 || D5 !== 1'b0 || tally_o() !== 4'(m_tally)) begin
            fails++;
            $display("FAIL release_no_event: tally=%0d D5=%b expected 1 0", tally_o(), D5);
        end
    endtask

    task automatic test_random();
        logic [2:0] pv = 3'b111;
        int hold_left [3];
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    pv[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = int'($urandom_range(1, 10));
                end else begin
                    hold_left[b]--;
                end
            end
            {PMOD3, PMOD2, PMOD1} = pv;
            if (c == 1700) begin
                RST_N = 1'b0;
                model_reset();
                step();
                RST_N = 1'b1;
            end
            step();
            tests++;
            if (tally_o() !== 4'(m_tally) || D5 !== in_window(open_edge, WIN)) begin
                fails++;
                $display("FAIL random_main c=%0d: tally=%0d D5=%b expected %0d %b",
                         c, tally_o(), D5, m_tally, in_window(open_edge, WIN));
            end
            tests++;
            if (tally_l() !== 4'(m_tally2) || L5 !== in_window(open_edge2, WIN2)) begin
                fails++;
                $display("FAIL random_long c=%0d: tally=%0d L5=%b expected %0d %b",
                         c, tally_l(), L5, m_tally2, in_window(open_edge2, WIN2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_simultaneous();
        test_saturation();
        test_lockout();
        test_reset_mid();
        test_release_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
